// File: rtl/ov5640_capture.sv
// ----------------------------------------------------------------------------
// ov5640_capture
//   DVP capture front end for the OV5640 sensor. Registers the 8-bit parallel
//   bus in the PCLK domain, pairs consecutive bytes within an HREF window into
//   RGB565 pixels, and blanks the output stream until WAIT_FRAMES vsync rising
//   edges have been seen after reset (sensor register settling).
//
//   Optional feature: define OV5640_CAPTURE_SIZE_CHECK_EN to build the
//   line-length / frame-height checker driving size_err. When undefined,
//   size_err is tied low and the rest of the block is cycle-identical.
//
// Ports
//   clk              in   sensor pixel clock (rising edge)
//   rst              in   asynchronous active-high reset
//   cam_vsync        in   sensor VSYNC, active high
//   cam_href         in   sensor HREF, active high
//   cam_data[7:0]    in   sensor data bus
//   cmos_frame_vsync out  registered VSYNC gated by frame_ok
//   cmos_frame_href  out  registered HREF gated by frame_ok
//   cmos_frame_valid out  one-cycle strobe, cmos_wr_data holds a pixel
//   cmos_wr_data     out  RGB565 pixel {first byte, second byte}
//   frame_ok         out  high once WAIT_FRAMES frames have been skipped
//   size_err         out  sticky line-length / frame-height mismatch
// ----------------------------------------------------------------------------
module ov5640_capture #(
  parameter int WAIT_FRAMES = 10,
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        cmos_frame_vsync,
  output logic        cmos_frame_href,
  output logic        cmos_frame_valid,
  output logic [15:0] cmos_wr_data,
  output logic        frame_ok,
  output logic        size_err
);

  localparam logic [7:0] WAIT_CNT = 8'(WAIT_FRAMES);

  logic        vs_d0_q, vs_d1_q, hr_d0_q;
  logic [7:0]  dat_d0_q;
  logic [7:0]  skip_cnt_q, skip_cnt_d;
  logic        frame_ok_q, frame_ok_d;
  logic        byte_flag_q, byte_flag_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        valid_q, valid_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic        vs_rise;
  logic        pair_done;

  assign vs_rise   = vs_d0_q & ~vs_d1_q;
  // Second byte of a pair only counts while HREF is still high; an odd
  // trailing byte leaves byte_flag set into the blanking cycle and is dropped.
  assign pair_done = byte_flag_q & hr_d0_q;

  always_comb begin
    skip_cnt_d  = skip_cnt_q;
    frame_ok_d  = frame_ok_q;
    byte_flag_d = 1'b0;
    hi_d        = hi_q;
    wr_data_d   = wr_data_q;
    valid_d     = 1'b0;

    if (WAIT_FRAMES == 0) begin
      frame_ok_d = 1'b1;
    end else if (vs_rise && (skip_cnt_q != WAIT_CNT)) begin
      skip_cnt_d = skip_cnt_q + 8'd1;
      if (skip_cnt_d == WAIT_CNT) frame_ok_d = 1'b1;
    end

    if (hr_d0_q) byte_flag_d = ~byte_flag_q;
    if (!byte_flag_q) hi_d = dat_d0_q;
    if (pair_done) begin
      wr_data_d = {hi_q, dat_d0_q};
      valid_d   = frame_ok_q;
    end

    vsync_d = frame_ok_q & vs_d0_q;
    href_d  = frame_ok_q & hr_d0_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d0_q     <= 1'b0;
      vs_d1_q     <= 1'b0;
      hr_d0_q     <= 1'b0;
      dat_d0_q    <= 8'h00;
      skip_cnt_q  <= 8'h00;
      frame_ok_q  <= 1'b0;
      byte_flag_q <= 1'b0;
      hi_q        <= 8'h00;
      wr_data_q   <= 16'h0000;
      valid_q     <= 1'b0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
    end else begin
      vs_d0_q     <= cam_vsync;
      vs_d1_q     <= vs_d0_q;
      hr_d0_q     <= cam_href;
      dat_d0_q    <= cam_data;
      skip_cnt_q  <= skip_cnt_d;
      frame_ok_q  <= frame_ok_d;
      byte_flag_q <= byte_flag_d;
      hi_q        <= hi_d;
      wr_data_q   <= wr_data_d;
      valid_q     <= valid_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
    end
  end

  assign cmos_frame_vsync = vsync_q;
  assign cmos_frame_href  = href_q;
  assign cmos_frame_valid = valid_q;
  assign cmos_wr_data     = wr_data_q;
  assign frame_ok         = frame_ok_q;

`ifdef OV5640_CAPTURE_SIZE_CHECK_EN
  logic        hr_d1_q;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic        err_q, err_d;
  logic        hr_fall;

  assign hr_fall = hr_d1_q & ~hr_d0_q;

  // Line check is resolved before the frame check so that a line ending in
  // the same cycle as a vsync edge is included in the line count.
  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    err_d      = err_q;
    if (valid_d) pix_cnt_d = pix_cnt_q + 16'd1;
    if (hr_fall) begin
      if (frame_ok_q && (pix_cnt_q != 16'(H_ACTIVE))) err_d = 1'b1;
      pix_cnt_d  = 16'd0;
      line_cnt_d = line_cnt_q + 16'd1;
    end
    if (vs_rise) begin
      if (frame_ok_q && (line_cnt_d != 16'(V_ACTIVE))) err_d = 1'b1;
      line_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hr_d1_q    <= 1'b0;
      pix_cnt_q  <= 16'd0;
      line_cnt_q <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      hr_d1_q    <= hr_d0_q;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      err_q      <= err_d;
    end
  end

  assign size_err = err_q;
`else
  assign size_err = 1'b0;
`endif

endmodule

// File: tb/tb_ov5640_capture.sv
// ----------------------------------------------------------------------------
// tb_ov5640_capture
//   Two instances share one stimulus stream: u_w0 (WAIT_FRAMES=0) passes data
//   from reset, u_w2 (WAIT_FRAMES=2) must blank two frames. Both use an 8x4
//   frame geometry for the optional size checker.
// ----------------------------------------------------------------------------
module tb_ov5640_capture;

`ifdef OV5640_CAPTURE_SIZE_CHECK_EN
  localparam bit SZ = 1'b1;
`else
  localparam bit SZ = 1'b0;
`endif
  localparam int HA = 8;
  localparam int VA = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cam_vsync = 1'b0;
  logic cam_href  = 1'b0;
  logic [7:0] cam_data = 8'h00;

  logic o0_vs, o0_hr, o0_v, o0_ok, o0_err;
  logic o1_vs, o1_hr, o1_v, o1_ok, o1_err;
  logic [15:0] o0_d, o1_d;

  always #5 clk = ~clk;

  ov5640_capture #(.WAIT_FRAMES(0), .H_ACTIVE(HA), .V_ACTIVE(VA)) u_w0 (
    .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .cmos_frame_vsync(o0_vs), .cmos_frame_href(o0_hr),
    .cmos_frame_valid(o0_v), .cmos_wr_data(o0_d), .frame_ok(o0_ok),
    .size_err(o0_err));

  ov5640_capture #(.WAIT_FRAMES(2), .H_ACTIVE(HA), .V_ACTIVE(VA)) u_w2 (
    .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .cmos_frame_vsync(o1_vs), .cmos_frame_href(o1_hr),
    .cmos_frame_valid(o1_v), .cmos_wr_data(o1_d), .frame_ok(o1_ok),
    .size_err(o1_err));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state, index 0 = u_w0, 1 = u_w2.
  int m_w [2] = '{0, 2};
  int m_pulses [2];
  bit m_ok [2];
  int m_lines [2];
  bit m_err [2];
  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];

  logic [15:0] rx0 [$];
  logic [15:0] rx1 [$];
  int rxc0 [$];
  int cnt_vs [2];
  int str1 = 0;
  logic [7:0] lbuf [0:31];

  typedef struct {
    int          n;
    logic [47:0] b;
    int          npix;
    logic [47:0] px;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    bit v0p, v1p;
    v0p = 1'b0;
    v1p = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        v0p = 1'b0;
        v1p = 1'b0;
      end else begin
        if (o0_v) begin
          chk("strobe_gap_w0", {31'd0, v0p}, 0);
          rx0.push_back(o0_d);
          rxc0.push_back(cyc);
        end
        if (o1_v) begin
          chk("strobe_gap_w2", {31'd0, v1p}, 0);
          rx1.push_back(o1_d);
          str1++;
        end
        if (o1_hr) chk("href_gate_w2", {31'd0, m_ok[1]}, 1);
        if (o0_vs) cnt_vs[0]++;
        if (o1_vs) cnt_vs[1]++;
        v0p = o0_v;
        v1p = o1_v;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pulses[d] = 0;
      m_ok[d]     = (m_w[d] == 0);
      m_lines[d]  = 0;
      m_err[d]    = 1'b0;
    end
    exp0.delete(); exp1.delete();
    rx0.delete(); rx1.delete(); rxc0.delete();
  endtask

  // One HREF window of n bytes from lbuf: pairs become pixels when passed,
  // a trailing odd byte is discarded.
  task automatic model_line(input int n);
    for (int d = 0; d < 2; d++) begin
      if (m_ok[d]) begin
        for (int k = 0; k < n / 2; k++) begin
          if (d == 0) exp0.push_back({lbuf[2*k], lbuf[2*k+1]});
          else        exp1.push_back({lbuf[2*k], lbuf[2*k+1]});
        end
        if (SZ && (n / 2 != HA)) m_err[d] = 1'b1;
      end
      m_lines[d]++;
    end
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cam_vsync = 1'b0;
      cam_href  = 1'b0;
      cam_data  = 8'($urandom);
    end
  endtask

  task automatic drive_line(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = lbuf[i];
    end
    @(negedge clk);
    cam_href = 1'b0;
    cam_data = 8'($urandom);
    model_line(n);
    drive_idle(3);
  endtask

  task automatic cmp_rx();
    chk("pix_count_w0", rx0.size(), exp0.size());
    for (int i = 0; i < rx0.size() && i < exp0.size(); i++) chk("pix_w0", rx0[i], exp0[i]);
    chk("pix_count_w2", rx1.size(), exp1.size());
    for (int i = 0; i < rx1.size() && i < exp1.size(); i++) chk("pix_w2", rx1[i], exp1[i]);
    rx0.delete(); rx1.delete(); rxc0.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic frame(input int nlines, input int nbytes);
    repeat (nlines) begin
      for (int i = 0; i < nbytes; i++) lbuf[i] = 8'($urandom);
      drive_line(nbytes);
      cmp_rx();
    end
  endtask

  task automatic drive_vsync(input int len);
    bit okb [2];
    for (int d = 0; d < 2; d++) begin
      okb[d] = m_ok[d];
      if (SZ && okb[d] && (m_lines[d] != VA)) m_err[d] = 1'b1;
      m_lines[d] = 0;
      m_pulses[d]++;
      if (m_pulses[d] >= m_w[d]) m_ok[d] = 1'b1;
      cnt_vs[d] = 0;
    end
    repeat (len) begin
      @(negedge clk);
      cam_vsync = 1'b1;
    end
    drive_idle(5);
    for (int d = 0; d < 2; d++) begin
      if (okb[d]) chk("vsync_out_len", cnt_vs[d], len);
      else if (!m_ok[d]) chk("vsync_out_blank", cnt_vs[d], 0);
    end
    chk("frame_ok_w0", {31'd0, o0_ok}, {31'd0, m_ok[0]});
    chk("frame_ok_w2", {31'd0, o1_ok}, {31'd0, m_ok[1]});
    chk("size_err_vs_w0", {31'd0, o0_err}, {31'd0, m_err[0]});
    chk("size_err_vs_w2", {31'd0, o1_err}, {31'd0, m_err[1]});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_w0"}, {o0_vs, o0_hr, o0_v, o0_d, o0_ok, o0_err}, 0);
    chk({tag, "_w2"}, {o1_vs, o1_hr, o1_v, o1_d, o1_ok, o1_err}, 0);
  endtask

  initial begin : main
    int c0;
    logic [47:0] tb, tp;

    tbl[0] = '{n: 4, b: 48'hA53C_FF00_0000, npix: 2, px: 48'hA53C_FF00_0000};
    tbl[1] = '{n: 5, b: 48'h0102_0304_0500, npix: 2, px: 48'h0102_0304_0000};
    tbl[2] = '{n: 2, b: 48'h0607_0000_0000, npix: 1, px: 48'h0607_0000_0000};
    tbl[3] = '{n: 1, b: 48'hEE00_0000_0000, npix: 0, px: 48'h0000_0000_0000};
    tbl[4] = '{n: 6, b: 48'h1234_5678_9ABC, npix: 3, px: 48'h1234_5678_9ABC};

    // Reset state
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("frame_ok_w0_after_rst", {31'd0, o0_ok}, 1);
    chk("frame_ok_w2_after_rst", {31'd0, o1_ok}, 0);

    // Byte pairing latency on the pass-through instance
    lbuf[0] = 8'hA5; lbuf[1] = 8'h3C; lbuf[2] = 8'hFF; lbuf[3] = 8'h00;
    @(negedge clk); c0 = cyc; cam_href = 1'b1; cam_data = 8'hA5;
    @(negedge clk); chk("href_lat_early", {31'd0, o0_hr}, 0); cam_data = 8'h3C;
    @(negedge clk); chk("href_lat", {31'd0, o0_hr}, 1); cam_data = 8'hFF;
    @(negedge clk); cam_data = 8'h00;
    @(negedge clk); cam_href = 1'b0;
    drive_idle(3);
    model_line(4);
    chk("pair_count", rx0.size(), 2);
    if (rx0.size() == 2) begin
      chk("pair0_data", rx0[0], 16'hA53C);
      chk("pair0_cycle", rxc0[0], c0 + 3);
      chk("pair1_data", rx0[1], 16'hFF00);
      chk("pair1_cycle", rxc0[1], c0 + 5);
    end
    chk("w2_silent_hand", rx1.size(), 0);
    rx0.delete(); rx1.delete(); rxc0.delete(); exp0.delete(); exp1.delete();

    // Table of line patterns, including odd-length lines
    for (int i = 0; i < 5; i++) begin
      tb = tbl[i].b;
      tp = tbl[i].px;
      for (int j = 0; j < tbl[i].n; j++) lbuf[j] = tb[47-8*j -: 8];
      drive_line(tbl[i].n);
      chk("tbl_count", rx0.size(), tbl[i].npix);
      for (int k = 0; k < rx0.size() && k < tbl[i].npix; k++)
        chk("tbl_pix", rx0[k], tp[47-16*k -: 16]);
      chk("w2_silent_tbl", rx1.size(), 0);
      rx0.delete(); rx1.delete(); rxc0.delete(); exp0.delete(); exp1.delete();
    end

    // Frame skip: frames 1 and 2 blanked on u_w2, frame 3 passes 32 pixels
    frame(4, 16);
    drive_vsync(3);
    frame(4, 16);
    chk("w2_frame2_silent", str1, 0);
    drive_vsync(3);
    str1 = 0;
    frame(4, 16);
    chk("w2_frame3_strobes", str1, 32);
    drive_vsync(3);

    // Short line after frame_ok, then the flag must stay set
    frame(1, 14);
    chk("size_err_short", {31'd0, o1_err}, {31'd0, m_err[1]});
    chk("size_err_short_model", {31'd0, o1_err}, {31'd0, SZ});
    frame(1, 16);
    chk("size_err_sticky", {31'd0, o1_err}, {31'd0, SZ});

    // Random line lengths and data
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 3; l++) frame(1, 1 + int'($urandom_range(19)));
      drive_vsync(2 + int'($urandom_range(3)));
    end

    // Reset in the middle of a passed line
    for (int i = 0; i < 16; i++) lbuf[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = lbuf[i];
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("reset_midline");
    model_reset();
    cam_href = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_idle(2);
    chk("frame_ok_w2_rst_again", {31'd0, o1_ok}, 0);
    chk("size_err_cleared", {31'd0, o1_err}, 0);

    frame(4, 16);
    drive_vsync(3);
    frame(4, 16);
    drive_vsync(3);
    frame(4, 16);
    drive_vsync(3);
    chk("size_err_good_frame", {31'd0, o1_err}, 0);
    frame(3, 16);
    drive_vsync(3);
    chk("size_err_3lines", {31'd0, o1_err}, {31'd0, SZ});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
